// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the memory responder.
package mem_pkg;

    localparam int DEPTH_DEF = 256;
    localparam int AW_DEF    = 8;
    localparam int WAIT_DEF  = 2;
    localparam int DATA_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int LANES     = DATA_W / BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Word RAM with a byte-enable write port and a registered read port; contents are not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [LANES-1:0]  i_be,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][BYTE_W*i +: BYTE_W] <= i_wdata[BYTE_W*i +: BYTE_W];
                end
            end
        end
        if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures a CPU request, waits a fixed latency, then does the word access.
//   state   | meaning
//   ST_IDLE | waiting for req; accepts on req=1
//   ST_WAIT | request captured, counting down access latency
//   ST_RESP | access done this cycle; ready=1, busy=1
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int AW          = AW_DEF,
    parameter int WAIT_CYCLES = WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LANES-1:0]  be,
    output logic              busy,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic [DATA_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [LANES-1:0]   r_be;
    logic               r_busy;
    logic               r_ready;
    logic               r_err;
    logic               r_rd_valid;

    logic               w_accept;
    logic               w_go_resp;
    logic               w_acc_we;
    logic [DATA_W-1:0]  w_acc_addr;
    logic [DATA_W-1:0]  w_acc_wdata;
    logic [LANES-1:0]   w_acc_be;
    logic               w_in_range;
    logic               w_wr_en;
    logic               w_rd_en;
    logic [DATA_W-1:0]  w_arr_rdata;
    logic               w_unused;

    assign w_accept  = (r_state == ST_IDLE) && req;
    assign w_go_resp = (w_accept && ZERO_WAIT) || ((r_state == ST_WAIT) && (r_cnt == 4'd1));

    // With zero wait the access happens on the accept edge, so it must use the live inputs.
    assign w_acc_we    = (r_state == ST_IDLE) ? we    : r_we;
    assign w_acc_addr  = (r_state == ST_IDLE) ? addr  : r_addr;
    assign w_acc_wdata = (r_state == ST_IDLE) ? wdata : r_wdata;
    assign w_acc_be    = (r_state == ST_IDLE) ? be    : r_be;

    assign w_in_range = ~|w_acc_addr[DATA_W-1:AW+2];
    // Gating with rst_n keeps a write from landing on an edge where reset is still asserted.
    assign w_wr_en    = w_go_resp && w_acc_we && w_in_range && rst_n;
    assign w_rd_en    = w_go_resp && !w_acc_we && w_in_range && rst_n;
    assign w_unused   = ^w_acc_addr[1:0];

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_wr_en (w_wr_en),
        .i_rd_en (w_rd_en),
        .i_addr  (w_acc_addr[AW+1:2]),
        .i_wdata (w_acc_wdata),
        .i_be    (w_acc_be),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_be    <= be;
                        r_cnt   <= WAIT_LD;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_go_resp) begin
                r_state <= ST_RESP;
                r_ready <= 1'b1;
                r_err   <= !w_in_range;
                r_cnt   <= 4'd0;
                if (w_rd_en) begin
                    r_rd_valid <= 1'b1;
                end
            end
        end
    end

    assign busy  = r_busy;
    assign ready = r_ready;
    assign err   = r_err;
    assign rdata = r_rd_valid ? w_arr_rdata : '0;

endmodule
